hazard_fwd_unit: RTL
====================

// Module: hazard_fwd_unit
// PURPOSE
//  Next-generation forwarding and hazard unit for the 5-stage pipeline.
//  - Generates per-operand ALU forwarding selects: EX/MEM has priority over MEM/WB; register 0 never forwards.
//  - Detects load-use hazards and stalls IF/ID.
//  - Tracks one outstanding multi-cycle MUL/DIV write with an FSM and down-counter, and stalls dependent instructions until it completes.
//  - Sits beside ID/EX control; drives the ALU input muxes, PC/IF_ID write enables and the ID_EX bubble mux.
// PARAMETERS
//  ADDR_W   5  register address width
//  NUM_SRC  2  source operands per instruction (operand 0 = rs, operand 1 = rt, ...)
//  MD_LAT   4  MUL/DIV latency in cycles, >= 2
// PORTS
//  clk_i               in   1                 clock, rising edge
//  rst_i               in   1                 asynchronous, active-high reset
//  ID_EX_SRCaddr_i     in   NUM_SRC*ADDR_W    EX-stage source addresses; operand k at [k*ADDR_W +: ADDR_W]
//  EX_MEM_RegDst_i     in   ADDR_W            EX/MEM destination
//  EX_MEM_RegWrite_i   in   1                 EX/MEM writes register file
//  MEM_WB_RegDst_i     in   ADDR_W            MEM/WB destination
//  MEM_WB_RegWrite_i   in   1                 MEM/WB writes register file
//  IF_ID_SRCaddr_i     in   NUM_SRC*ADDR_W    ID-stage source addresses
//  ID_EX_RegDst_i      in   ADDR_W            ID/EX destination
//  ID_EX_MemRead_i     in   1                 ID/EX is a load
//  md_start_i          in   1                 MUL/DIV issue strobe
//  md_dst_i            in   ADDR_W            MUL/DIV destination, sampled with md_start_i
//  select_ALU_data_o   out  2*NUM_SRC         per-operand select: 00 regfile, 01 MEM/WB, 10 EX/MEM
//  stall_o             out  1                 hold PC and IF/ID
//  bubble_o            out  1                 zero ID/EX control (always equals stall_o)
//  md_busy_o           out  1                 MUL/DIV occupied
//  md_done_o           out  1                 final MUL/DIV cycle pulse
//  md_err_o            out  1                 sticky: md_start_i seen while busy
// BEHAVIOUR
//  Forwarding (combinational, per operand k, a = operand k address):
//  - EX hit: EX_MEM_RegWrite_i && EX_MEM_RegDst_i != 0 && EX_MEM_RegDst_i == a.
//  - MEM hit: MEM_WB_RegWrite_i && MEM_WB_RegDst_i != 0 && MEM_WB_RegDst_i == a.
//  - Select = EX hit ? 10 : MEM hit ? 01 : 00.
//  Load-use hazard: ID_EX_MemRead_i && ID_EX_RegDst_i != 0 && ID_EX_RegDst_i equals any IF_ID source.
//  FSM states IDLE, BUSY; counter cnt is clog2(MD_LAT) bits.
//  - IDLE + md_start_i -> BUSY, cnt = MD_LAT-1, pend_dst = md_dst_i.
//  - BUSY with cnt != 0: cnt decrements each cycle.
//  - BUSY with cnt == 0: md_done_o = 1 for this cycle; next state IDLE, unless md_start_i is also high.
//    In that case a back-to-back issue is accepted: stay BUSY, reload cnt and pend_dst.
//  - BUSY with cnt != 0 + md_start_i: start ignored, md_err_o set; cleared only by reset.
//  - md_busy_o = (state == BUSY).
//  - Busy window is exactly MD_LAT cycles, starting the cycle after the start edge.
//  MD hazard: md_busy_o && pend_dst != 0 && pend_dst equals any IF_ID source.
//  - The hazard holds through the md_done_o cycle and releases the following cycle.
//  - md_dst_i == 0 still occupies the unit but never raises a hazard.
//  stall_o = load-use hazard | MD hazard.
//  - The MD term uses registered state only; the load-use term is combinational.
//  Reset, asynchronous, also mid-operation: state IDLE, cnt 0, pend_dst 0, md_err_o 0.
//  - While rst_i = 1 all outputs are forced to 0, including the selects and stall_o.
// CONFIGURATION
//  HAZARD_PERF_EN defined:
//  - Adds outputs perf_lu_stall_o [15:0], perf_md_stall_o [15:0] and perf_fwd_o [15:0].
//  - Each is a saturating count (stops at 16'hFFFF) of, respectively:
//    cycles with the load-use hazard set; cycles with the MD hazard set; cycles where any operand select != 00.
//  - All counters reset to 0.
//  HAZARD_PERF_EN undefined: these ports and counters do not exist; all other behaviour is identical.
// TESTING
//  1. EX_MEM dst=3 wr=1, MEM_WB dst=3 wr=1, rs=3 -> select op0=10; drop EX wr -> 01; dst=0 both -> 00.
//  2. ID_EX MemRead=1 dst=5, IF_ID rt=5 -> stall_o=bubble_o=1 same cycle; MemRead=0 -> 0.
//  3. md_start dst=7 (MD_LAT=4), IF_ID rs=7 -> stall 4 cycles, md_done_o in 4th, stall 0 on 5th.
//  4. md_start again in the done cycle -> md_busy_o stays 1 for a further 4 cycles, md_err_o=0;
//     md_start at cnt=2 -> md_err_o=1 and sticky.
//  5. rst_i pulsed mid-BUSY (cnt=1) -> md_busy_o, stall_o, md_err_o = 0 immediately; IDLE after release.
//  6. HAZARD_PERF_EN: 70000 load-use cycles -> perf_lu_stall_o = 16'hFFFF (saturated).

Source files
------------

// File: rtl/hazard_fwd_unit.sv
// Forwarding selects, load-use stall and one-deep MUL/DIV scoreboard.
// Optional HAZARD_PERF_EN adds saturating stall/forward counters.
module hazard_fwd_unit #(
  parameter int ADDR_W  = 5,
  parameter int NUM_SRC = 2,
  parameter int MD_LAT  = 4
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic [NUM_SRC*ADDR_W-1:0] ID_EX_SRCaddr_i,
  input  logic [ADDR_W-1:0]         EX_MEM_RegDst_i,
  input  logic                      EX_MEM_RegWrite_i,
  input  logic [ADDR_W-1:0]         MEM_WB_RegDst_i,
  input  logic                      MEM_WB_RegWrite_i,
  input  logic [NUM_SRC*ADDR_W-1:0] IF_ID_SRCaddr_i,
  input  logic [ADDR_W-1:0]         ID_EX_RegDst_i,
  input  logic                      ID_EX_MemRead_i,
  input  logic                      md_start_i,
  input  logic [ADDR_W-1:0]         md_dst_i,
  output logic [2*NUM_SRC-1:0]      select_ALU_data_o,
  output logic                      stall_o,
  output logic                      bubble_o,
  output logic                      md_busy_o,
  output logic                      md_done_o,
  output logic                      md_err_o
`ifdef HAZARD_PERF_EN
  ,
  output logic [15:0]               perf_lu_stall_o,
  output logic [15:0]               perf_md_stall_o,
  output logic [15:0]               perf_fwd_o
`endif
);

  localparam int CNT_W = $clog2(MD_LAT);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [ADDR_W-1:0]  pend_q, pend_d;
  logic               err_q, err_d;
  logic               done;

  logic [2*NUM_SRC-1:0] sel;
  logic                 lu_haz;
  logic                 md_haz;
  logic                 busy;

  // Per-operand forwarding select, EX/MEM wins over MEM/WB
  always_comb begin
    sel = '0;
    for (int k = 0; k < NUM_SRC; k++) begin
      if (EX_MEM_RegWrite_i && EX_MEM_RegDst_i != '0 &&
          EX_MEM_RegDst_i == ID_EX_SRCaddr_i[k*ADDR_W +: ADDR_W])
        sel[2*k +: 2] = 2'b10;
      else if (MEM_WB_RegWrite_i && MEM_WB_RegDst_i != '0 &&
               MEM_WB_RegDst_i == ID_EX_SRCaddr_i[k*ADDR_W +: ADDR_W])
        sel[2*k +: 2] = 2'b01;
    end
  end

  assign busy = (state_q == BUSY);

  // Load-use and pending MUL/DIV dependency checks on ID sources
  always_comb begin
    lu_haz = 1'b0;
    md_haz = 1'b0;
    for (int k = 0; k < NUM_SRC; k++) begin
      if (ID_EX_MemRead_i && ID_EX_RegDst_i != '0 &&
          ID_EX_RegDst_i == IF_ID_SRCaddr_i[k*ADDR_W +: ADDR_W])
        lu_haz = 1'b1;
      if (busy && pend_q != '0 &&
          pend_q == IF_ID_SRCaddr_i[k*ADDR_W +: ADDR_W])
        md_haz = 1'b1;
    end
  end

  // MUL/DIV tracker next-state: countdown, back-to-back reissue, error
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    pend_d  = pend_q;
    err_d   = err_q;
    done    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (md_start_i) begin
          state_d = BUSY;
          cnt_d   = CNT_W'(MD_LAT - 1);
          pend_d  = md_dst_i;
        end
      end
      BUSY: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CNT_W'(1);
          if (md_start_i)
            err_d = 1'b1;
        end else begin
          done = 1'b1;
          if (md_start_i) begin
            cnt_d  = CNT_W'(MD_LAT - 1);
            pend_d = md_dst_i;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Tracker state registers
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      pend_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pend_q  <= pend_d;
      err_q   <= err_d;
    end
  end

  // Outputs are held low while reset is asserted
  always_comb begin
    select_ALU_data_o = rst_i ? '0 : sel;
    stall_o           = ~rst_i & (lu_haz | md_haz);
    bubble_o          = ~rst_i & (lu_haz | md_haz);
    md_busy_o         = ~rst_i & busy;
    md_done_o         = ~rst_i & done;
    md_err_o          = ~rst_i & err_q;
  end

`ifdef HAZARD_PERF_EN
  logic [15:0] lu_cnt_q, lu_cnt_d;
  logic [15:0] md_cnt_q, md_cnt_d;
  logic [15:0] fwd_cnt_q, fwd_cnt_d;

  // Saturating event counters
  always_comb begin
    lu_cnt_d  = lu_cnt_q;
    md_cnt_d  = md_cnt_q;
    fwd_cnt_d = fwd_cnt_q;
    if (lu_haz && lu_cnt_q != 16'hFFFF)
      lu_cnt_d = lu_cnt_q + 16'd1;
    if (md_haz && md_cnt_q != 16'hFFFF)
      md_cnt_d = md_cnt_q + 16'd1;
    if (|sel && fwd_cnt_q != 16'hFFFF)
      fwd_cnt_d = fwd_cnt_q + 16'd1;
  end

  // Counter registers
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      lu_cnt_q  <= '0;
      md_cnt_q  <= '0;
      fwd_cnt_q <= '0;
    end else begin
      lu_cnt_q  <= lu_cnt_d;
      md_cnt_q  <= md_cnt_d;
      fwd_cnt_q <= fwd_cnt_d;
    end
  end

  assign perf_lu_stall_o = lu_cnt_q;
  assign perf_md_stall_o = md_cnt_q;
  assign perf_fwd_o      = fwd_cnt_q;
`endif

endmodule
